// File: rtl/vga_instr_pkg.sv
// Shared definitions for the instruction dispatch path.
//   - Opcode ranges (must match the values cpu_interface emits).
//   - Dispatcher FSM state encoding.
//   - error_code values reported back to cpu_interface.
//   - Index of the graphics-mode bit inside mode_control.
//   - decode_op(): opcode + mode -> {valid, unit select, unit-local op}.
package vga_instr_pkg;

  // Text engine opcodes occupy 0x00..0x03 and pixel engine opcodes 0x10..0x14.
  localparam logic [7:0] OP_TEXT_FIRST = 8'h00;
  localparam logic [7:0] OP_TEXT_LAST  = 8'h03;
  localparam logic [7:0] OP_PIX_FIRST  = 8'h10;
  localparam logic [7:0] OP_PIX_LAST   = 8'h14;

  // mode_control bit: 0 = text mode, 1 = graphics mode.
  localparam int MODE_GRAPHICS_BIT = 0;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNIT     = 2'd1;
  localparam logic [1:0] ERR_REJECTED = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;  // opcode known and legal in the current mode
    logic       pix;    // 1 = pixel engine, 0 = text engine
    logic [2:0] op;     // unit-local operation index
  } decode_t;

  function automatic decode_t decode_op(input logic [7:0] opcode, input logic graphics);
    decode_t d;
    d = '0;
    // The text range starts at zero, so only the upper bound needs testing.
    if (opcode <= OP_TEXT_LAST) begin
      d.pix   = 1'b0;
      d.op    = 3'(opcode - OP_TEXT_FIRST);
      d.valid = !graphics;
    end else if (opcode >= OP_PIX_FIRST && opcode <= OP_PIX_LAST) begin
      d.pix   = 1'b1;
      d.op    = 3'(opcode - OP_PIX_FIRST);
      d.valid = graphics;
    end
    return d;
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// WAIT-phase watchdog for the instruction dispatcher.
// Ports:
//   phi2, reset_n : clock, asynchronous active-low reset
//   clear         : zero the counter (asserted in ISSUE)
//   enable        : count this cycle (asserted in WAIT)
//   expired       : high during the TIMEOUT_CYCLES-th enabled cycle
// TIMEOUT_CYCLES = 0 disables the watchdog; expired then never rises.
module dispatch_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic phi2,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW       = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST_INT = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int MAX_INT  = (TIMEOUT_CYCLES < 1) ? 0 : TIMEOUT_CYCLES;
  localparam logic [CW-1:0] LAST    = CW'(LAST_INT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INT);
  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);

  logic [CW-1:0] count;

  // count holds the number of enabled cycles already completed, so during
  // the k-th enabled cycle it reads k-1. It saturates rather than wraps.
  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != MAX_CNT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = ENABLED && enable && (count == LAST);

endmodule

// File: rtl/instruction_dispatcher.sv
// Sequences one instruction from cpu_interface onto the text or pixel engine.
// Ports:
//   phi2, reset_n            : clock, asynchronous active-low reset
//   instruction              : opcode, valid with instruction_start
//   instruction_start        : one-cycle launch pulse (ignored unless idle)
//   mode_control             : bit MODE_GRAPHICS_BIT selects graphics mode
//   instruction_busy         : high whenever the FSM is not idle
//   instruction_finished     : one-cycle pulse in DONE
//   instruction_error        : error_code != 0, held until next accepted start
//   error_code               : none / unit error / rejected / timeout
//   result_0, result_1       : low / high byte of the captured unit result
//   text_start, pix_start    : unit launch pulses (ISSUE)
//   unit_op                  : unit-local operation, stable ISSUE..WAIT
//   text_abort, pix_abort    : abort pulse on the watchdog expiry cycle
//   text_done, pix_done      : unit completion pulses
//   text_error, pix_error    : unit error, sampled with done
//   text_result, pix_result  : unit result, sampled with done
//   fsm_state                : current FSM state (observation only)
//
// Handshake: a start pulse is taken only in IDLE. The selected unit gets
// exactly one *_start pulse and answers with a one-cycle *_done carrying
// error/result on the same cycle. done is sampled only in WAIT and only
// from the selected unit. Every output comes from registers, so no input
// reaches an output combinationally; as a consequence *_abort is decoded
// from the watchdog alone and still pulses if done lands on the expiry
// cycle, although done decides the outcome in that case.
module instruction_dispatcher
  import vga_instr_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        phi2,
  input  logic        reset_n,
  input  logic [7:0]  instruction,
  input  logic        instruction_start,
  input  logic [7:0]  mode_control,
  output logic        instruction_busy,
  output logic        instruction_finished,
  output logic        instruction_error,
  output logic [1:0]  error_code,
  output logic [7:0]  result_0,
  output logic [7:0]  result_1,
  output logic        text_start,
  output logic        pix_start,
  output logic [2:0]  unit_op,
  output logic        text_abort,
  output logic        pix_abort,
  input  logic        text_done,
  input  logic        pix_done,
  input  logic        text_error,
  input  logic        pix_error,
  input  logic [15:0] text_result,
  input  logic [15:0] pix_result,
  output state_t      fsm_state
);

  state_t  state_q, state_d;
  logic    sel_pix_q;
  decode_t dec;
  logic    unit_done, unit_err;
  logic [15:0] unit_res;
  logic    wd_clear, wd_enable, wd_expired;
  logic    unused_mode_bits;

  // Only the mode bit matters; the rest of mode_control belongs elsewhere.
  assign unused_mode_bits = ^mode_control;

  assign dec = decode_op(instruction, mode_control[MODE_GRAPHICS_BIT]);

  assign unit_done = sel_pix_q ? pix_done   : text_done;
  assign unit_err  = sel_pix_q ? pix_error  : text_error;
  assign unit_res  = sel_pix_q ? pix_result : text_result;

  dispatch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .phi2   (phi2),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_ff @(posedge phi2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sel_pix_q  <= 1'b0;
      unit_op    <= '0;
      error_code <= ERR_NONE;
      result_0   <= '0;
      result_1   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (instruction_start) begin
            error_code <= dec.valid ? ERR_NONE : ERR_REJECTED;
            // A rejected opcode leaves the unit selection untouched.
            if (dec.valid) begin
              sel_pix_q <= dec.pix;
              unit_op   <= dec.op;
            end
          end
        end
        ST_WAIT: begin
          // done takes priority over a coincident watchdog expiry.
          if (unit_done) begin
            result_0   <= unit_res[7:0];
            result_1   <= unit_res[15:8];
            error_code <= unit_err ? ERR_UNIT : ERR_NONE;
          end else if (wd_expired) begin
            error_code <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d              = state_q;
    instruction_busy     = 1'b1;
    instruction_finished = 1'b0;
    text_start           = 1'b0;
    pix_start            = 1'b0;
    text_abort           = 1'b0;
    pix_abort            = 1'b0;
    wd_clear             = 1'b0;
    wd_enable            = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instruction_busy = 1'b0;
        if (instruction_start) begin
          state_d = dec.valid ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        text_start = !sel_pix_q;
        pix_start  = sel_pix_q;
        wd_clear   = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wd_enable  = 1'b1;
        text_abort = wd_expired && !sel_pix_q;
        pix_abort  = wd_expired && sel_pix_q;
        if (unit_done || wd_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        instruction_finished = 1'b1;
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instruction_error = (error_code != ERR_NONE);
  assign fsm_state         = state_q;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Directed testbench for instruction_dispatcher with an 8-cycle watchdog.
module tb_instruction_dispatcher;
  import vga_instr_pkg::*;

  localparam int TMO = 8;

  logic        phi2 = 1'b0;
  logic        reset_n;
  logic [7:0]  instruction;
  logic        instruction_start;
  logic [7:0]  mode_control;
  logic        instruction_busy, instruction_finished, instruction_error;
  logic [1:0]  error_code;
  logic [7:0]  result_0, result_1;
  logic        text_start, pix_start, text_abort, pix_abort;
  logic [2:0]  unit_op;
  logic        text_done, pix_done, text_error, pix_error;
  logic [15:0] text_result, pix_result;
  state_t      fsm_state;

  int checks = 0;
  int errors = 0;
  logic prev_err;

  // ---------------- clock / DUT ----------------
  always #5 phi2 = ~phi2;

  instruction_dispatcher #(.TIMEOUT_CYCLES(TMO)) dut (
    .phi2                (phi2),
    .reset_n             (reset_n),
    .instruction         (instruction),
    .instruction_start   (instruction_start),
    .mode_control        (mode_control),
    .instruction_busy    (instruction_busy),
    .instruction_finished(instruction_finished),
    .instruction_error   (instruction_error),
    .error_code          (error_code),
    .result_0            (result_0),
    .result_1            (result_1),
    .text_start          (text_start),
    .pix_start           (pix_start),
    .unit_op             (unit_op),
    .text_abort          (text_abort),
    .pix_abort           (pix_abort),
    .text_done           (text_done),
    .pix_done            (pix_done),
    .text_error          (text_error),
    .pix_error           (pix_error),
    .text_result         (text_result),
    .pix_result          (pix_result),
    .fsm_state           (fsm_state)
  );

  // ---------------- vector table ----------------
  // done_at: WAIT cycle (1-based) on which the selected unit reports done,
  // 0 = never. flags = {foreign done in WAIT 1, done during ISSUE, restart}.
  // exp_abort: cycle of the abort pulse, 0 = none, -1 = not checked.
  typedef struct {
    logic [7:0]  instr;
    logic        mode;
    int          done_at;
    logic        uerr;
    logic [15:0] res;
    logic [2:0]  flags;
    int          exp_busy;
    logic        exp_start;
    logic        exp_pix;
    logic [2:0]  exp_op;
    logic [1:0]  exp_code;
    logic [15:0] exp_res;
    int          exp_abort;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] instr, input logic mode, input int done_at,
                              input logic uerr, input logic [15:0] res, input logic [2:0] flags,
                              input int exp_busy, input logic exp_start, input logic exp_pix,
                              input logic [2:0] exp_op, input logic [1:0] exp_code,
                              input logic [15:0] exp_res, input int exp_abort);
    vec_t v;
    v.instr = instr; v.mode = mode; v.done_at = done_at; v.uerr = uerr; v.res = res;
    v.flags = flags; v.exp_busy = exp_busy; v.exp_start = exp_start; v.exp_pix = exp_pix;
    v.exp_op = exp_op; v.exp_code = exp_code; v.exp_res = exp_res; v.exp_abort = exp_abort;
    return v;
  endfunction

  vec_t vecs[10];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_units();
    text_done = 1'b0; pix_done = 1'b0; text_error = 1'b0; pix_error = 1'b0;
    text_result = 16'h0; pix_result = 16'h0;
  endtask

  task automatic drive_unit(input logic pix, input logic err, input logic [15:0] res);
    if (pix) begin
      pix_done = 1'b1; pix_error = err; pix_result = res;
    end else begin
      text_done = 1'b1; text_error = err; text_result = res;
    end
  endtask

  // ---------------- driver: one instruction, called at a negedge ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int busy_n = 0, fin_n = 0, fin_c = 0, ts_n = 0, ps_n = 0, ab_n = 0, ab_c = 0;
    logic ab_pix = 1'b0;
    logic op_bad = 1'b0;
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, "_err_hold"}, instruction_error, prev_err);
    instruction       = v.instr;
    mode_control      = {7'b0, v.mode};
    instruction_start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge phi2);
      if (c == 1) check({tag, "_state1"}, fsm_state, v.exp_start ? ST_ISSUE : ST_DONE);
      if (!instruction_busy) begin
        clear_units();
        instruction_start = 1'b0;
        break;
      end
      busy_n++;
      if (instruction_finished) begin fin_n++; fin_c = c; end
      ts_n += int'(text_start);
      ps_n += int'(pix_start);
      if (text_abort || pix_abort) begin ab_n++; ab_c = c; ab_pix = pix_abort; end
      if (v.exp_start && c < v.exp_busy && unit_op !== v.exp_op) op_bad = 1'b1;
      // Inputs for the next edge; the mode flips to show it is not re-sampled.
      mode_control      = {7'b0, ~v.mode};
      instruction       = 8'h00;
      instruction_start = (c == 2) && v.flags[0];
      clear_units();
      if (c == 1 && v.flags[1]) drive_unit(v.exp_pix, 1'b1, 16'hDEAD);
      if (c == 2 && v.flags[2]) drive_unit(!v.exp_pix, 1'b1, 16'h5555);
      if (v.done_at > 0 && c == v.done_at + 1) drive_unit(v.exp_pix, v.uerr, v.res);
    end
    check({tag, "_busy_cycles"}, busy_n, v.exp_busy);
    check({tag, "_finished"}, {fin_n[15:0], fin_c[15:0]}, {16'd1, v.exp_busy[15:0]});
    check({tag, "_text_start"}, ts_n, (v.exp_start && !v.exp_pix) ? 1 : 0);
    check({tag, "_pix_start"}, ps_n, (v.exp_start && v.exp_pix) ? 1 : 0);
    if (v.exp_abort >= 0) begin
      check({tag, "_abort_n"}, ab_n, (v.exp_abort > 0) ? 1 : 0);
      if (v.exp_abort > 0) begin
        check({tag, "_abort_cyc"}, ab_c, v.exp_abort);
        check({tag, "_abort_unit"}, ab_pix, v.exp_pix);
      end
    end
    if (v.exp_start) check({tag, "_unit_op"}, op_bad, 1'b0);
    check({tag, "_code"}, error_code, v.exp_code);
    check({tag, "_error"}, instruction_error, v.exp_code != 2'd0);
    check({tag, "_result"}, {result_1, result_0}, v.exp_res);
    prev_err = (v.exp_code != 2'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = mk(8'h01, 1'b0, 4, 1'b0, 16'hBEEF, 3'b000,  6, 1'b1, 1'b0, 3'd1, 2'd0, 16'hBEEF,  0);
    vecs[1] = mk(8'h07, 1'b0, 0, 1'b0, 16'h0000, 3'b000,  1, 1'b0, 1'b0, 3'd0, 2'd2, 16'hBEEF,  0);
    vecs[2] = mk(8'h10, 1'b0, 0, 1'b0, 16'h0000, 3'b000,  1, 1'b0, 1'b0, 3'd0, 2'd2, 16'hBEEF,  0);
    vecs[3] = mk(8'h14, 1'b1, 2, 1'b1, 16'h1234, 3'b000,  4, 1'b1, 1'b1, 3'd4, 2'd1, 16'h1234,  0);
    vecs[4] = mk(8'h12, 1'b1, 0, 1'b0, 16'h9999, 3'b000, 10, 1'b1, 1'b1, 3'd2, 2'd3, 16'h1234,  9);
    vecs[5] = mk(8'h03, 1'b1, 0, 1'b0, 16'h0000, 3'b000,  1, 1'b0, 1'b0, 3'd0, 2'd2, 16'h1234,  0);
    vecs[6] = mk(8'h11, 1'b1, 8, 1'b0, 16'hA55A, 3'b000, 10, 1'b1, 1'b1, 3'd1, 2'd0, 16'hA55A, -1);
    vecs[7] = mk(8'h10, 1'b1, 3, 1'b0, 16'h00C3, 3'b111,  5, 1'b1, 1'b1, 3'd0, 2'd0, 16'h00C3,  0);
    vecs[8] = mk(8'h00, 1'b0, 1, 1'b0, 16'hFFFF, 3'b000,  3, 1'b1, 1'b0, 3'd0, 2'd0, 16'hFFFF,  0);
    vecs[9] = mk(8'hFF, 1'b0, 0, 1'b0, 16'h0000, 3'b000,  1, 1'b0, 1'b0, 3'd0, 2'd2, 16'hFFFF,  0);

    reset_n = 1'b0;
    instruction = 8'h00; instruction_start = 1'b0; mode_control = 8'h00;
    clear_units();
    prev_err = 1'b0;
    repeat (3) @(negedge phi2);
    check("rst_busy", instruction_busy, 1'b0);
    check("rst_outs", {instruction_finished, instruction_error, error_code, text_start, pix_start,
                       text_abort, pix_abort, unit_op}, 32'h0);
    check("rst_result", {result_1, result_0}, 16'h0000);
    check("rst_state", fsm_state, ST_IDLE);
    reset_n = 1'b1;
    @(negedge phi2);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset asserted in the middle of WAIT clears everything at once.
    instruction = 8'h02; mode_control = 8'h00; instruction_start = 1'b1;
    @(negedge phi2);
    instruction_start = 1'b0;
    repeat (2) @(negedge phi2);
    check("mid_wait_busy", instruction_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", {instruction_busy, fsm_state}, 3'b000);
    check("async_rst_outs", {instruction_finished, instruction_error, error_code, text_start, pix_start,
                             text_abort, pix_abort, unit_op}, 32'h0);
    check("async_rst_result", {result_1, result_0}, 16'h0000);
    @(negedge phi2);
    check("rst_no_abort", {text_abort, pix_abort}, 2'b00);
    reset_n = 1'b1;
    prev_err = 1'b0;
    @(negedge phi2);
    run_vec(mk(8'h13, 1'b1, 1, 1'b0, 16'h7E81, 3'b000, 3, 1'b1, 1'b1, 3'd3, 2'd0, 16'h7E81, 0), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
